// File: rtl/iob_mem_arbiter.sv
// ============================================================================
//  Module      : iob_mem_arbiter
//  Description : Two-master to one-slave IOb native-bus arbiter. A registered
//                grant selects one master at a time. Its request fields are
//                muxed to the slave, and the slave response is returned to
//                that master only.
//                Compile-time option MEM_ARB_RR_EN: when defined, ties are
//                broken round-robin. When undefined, master 0 has fixed
//                priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  // master 0
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  // master 1
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  // slave
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  // status
  output logic [1:0]          grant,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  // Index of the master that completed most recently. It resets to 1 so that
  // master 0 wins the first round-robin tie.
  logic   last_q, last_d;

  // State and last-served registers; an asynchronous reset drops any
  // in-flight response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Arbitration, request mux and response demux. All outputs are zero unless
  // a grant is active.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_rdata = '0;
    case (state_q)
      IDLE: begin
        // A slave ready seen here has no owner and is ignored.
        if (m0_valid && m1_valid) begin
`ifdef MEM_ARB_RR_EN
          state_d = (last_q == 1'b0) ? GNT1 : GNT0;
`else
          state_d = GNT0;
`endif
        end else if (m0_valid) begin
          state_d = GNT0;
        end else if (m1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0: begin
        // s_valid follows the master, but the grant is held until s_ready,
        // even if the master illegally drops its request.
        s_valid = m0_valid;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
        if (s_ready) begin
          m0_ready = 1'b1;
          m0_rdata = s_rdata;
          state_d  = IDLE;
          last_d   = 1'b0;
        end
      end
      GNT1: begin
        s_valid = m1_valid;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
        if (s_ready) begin
          m1_ready = 1'b1;
          m1_rdata = s_rdata;
          state_d  = IDLE;
          last_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant = {state_q == GNT1, state_q == GNT0};
  assign busy  = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_iob_mem_arbiter.sv
// ============================================================================
//  Module      : tb_iob_mem_arbiter
//  Description : Directed self-checking bench for iob_mem_arbiter. The
//                round-robin expectations are selected with MEM_ARB_RR_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              m0_valid, m1_valid, s_valid, s_ready;
  logic [ADDR_W-1:0] m0_addr, m1_addr, s_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, s_wdata, s_rdata, m0_rdata, m1_rdata;
  logic [3:0]        m0_wstrb, m1_wstrb, s_wstrb;
  logic              m0_ready, m1_ready, busy;
  logic [1:0]        grant;

  int n_vec = 0;
  int n_err = 0;

  iob_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; drive, then check at +1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_g [4];

  initial begin
`ifdef MEM_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    m0_valid = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready = 0; s_rdata = '0;

    // Reset state
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_s_valid", 32'(s_valid), 32'h0);
    chk("rst_s_addr", s_addr, 32'h0);
    chk("rst_ready", 32'({m1_ready, m0_ready}), 32'h0);
    tick(); tick();
    rst = 1'b1;

    // T1: write from m0 alone, slave answers one cycle after s_valid
    tick();
    m0_valid = 1; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF; m0_wstrb = 4'hF;
    #1 chk("t1_lat_s_valid", 32'(s_valid), 32'h0);
    tick();
    #1 chk("t1_s_valid", 32'(s_valid), 32'h1);
    chk("t1_s_addr", s_addr, 32'h100);
    chk("t1_s_wdata", s_wdata, 32'hDEADBEEF);
    chk("t1_s_wstrb", 32'(s_wstrb), 32'hF);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_m0_ready_early", 32'(m0_ready), 32'h0);
    tick();
    s_ready = 1;
    #1 chk("t1_m0_ready", 32'(m0_ready), 32'h1);
    chk("t1_m1_ready", 32'(m1_ready), 32'h0);
    tick();
    s_ready = 0; m0_valid = 0;
    #1 chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_idle_grant", 32'(grant), 32'h0);
    chk("t1_idle_s_valid", 32'(s_valid), 32'h0);

    // T2: read via m1
    m1_valid = 1; m1_addr = 32'h200; m1_wstrb = 4'h0;
    tick();
    s_ready = 1; s_rdata = 32'h12345678;
    #1 chk("t2_grant", 32'(grant), 32'h2);
    chk("t2_s_addr", s_addr, 32'h200);
    chk("t2_s_wstrb", 32'(s_wstrb), 32'h0);
    chk("t2_m1_rdata", m1_rdata, 32'h12345678);
    chk("t2_m1_ready", 32'(m1_ready), 32'h1);
    chk("t2_m0_ready", 32'(m0_ready), 32'h0);
    chk("t2_m0_rdata", m0_rdata, 32'h0);
    tick();
    s_ready = 0; m1_valid = 0;
    #1 chk("t2_idle_busy", 32'(busy), 32'h0);

    // T3: both masters request continuously for four transactions
    m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 4'h0;
    m1_valid = 1; m1_addr = 32'h20; m1_wstrb = 4'h0;
    for (int i = 0; i < 4; i++) begin
      tick();
      s_ready = 1; s_rdata = 32'hA000 + 32'(i);
      #1 chk("t3_grant", 32'(grant), 32'(exp_g[i]));
      chk("t3_s_addr", s_addr, (exp_g[i] == 2'b01) ? 32'h10 : 32'h20);
      chk("t3_m0_ready", 32'(m0_ready), 32'(exp_g[i] == 2'b01));
      chk("t3_m1_ready", 32'(m1_ready), 32'(exp_g[i] == 2'b10));
      tick();
      s_ready = 0;
      #1 chk("t3_gap_busy", 32'(busy), 32'h0);
    end
    m0_valid = 0; m1_valid = 0;

    // T4: m0 granted, slave stalls 5 cycles while m1 waits
    tick();
    m0_valid = 1; m0_addr = 32'h300;
    tick();
    m1_valid = 1; m1_addr = 32'h400;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t4_stall_grant", 32'(grant), 32'h1);
      chk("t4_stall_s_addr", s_addr, 32'h300);
      chk("t4_stall_ready", 32'({m1_ready, m0_ready}), 32'h0);
      tick();
    end
    s_ready = 1;
    #1 chk("t4_m0_ready", 32'(m0_ready), 32'h1);
    chk("t4_m1_ready_blocked", 32'(m1_ready), 32'h0);
    tick();
    s_ready = 0; m0_valid = 0;
    #1 chk("t4_gap_busy", 32'(busy), 32'h0);
    tick();
    s_ready = 1;
    #1 chk("t4_m1_grant", 32'(grant), 32'h2);
    chk("t4_m1_s_addr", s_addr, 32'h400);
    chk("t4_m1_ready", 32'(m1_ready), 32'h1);
    tick();
    s_ready = 0; m1_valid = 0;

    // T5: asynchronous reset while in GNT1
    m1_valid = 1; m1_addr = 32'h500;
    tick();
    #1 chk("t5_pre_s_valid", 32'(s_valid), 32'h1);
    rst = 1'b0;
    #1 chk("t5_rst_s_valid", 32'(s_valid), 32'h0);
    chk("t5_rst_grant", 32'(grant), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    m1_valid = 0;
    tick();
    rst = 1'b1;
    m0_valid = 1; m0_addr = 32'h600;
    tick();
    s_ready = 1;
    #1 chk("t5_after_grant", 32'(grant), 32'h1);
    chk("t5_after_s_addr", s_addr, 32'h600);
    chk("t5_after_m0_ready", 32'(m0_ready), 32'h1);
    tick();
    s_ready = 0; m0_valid = 0;

    // T6: stray s_ready in IDLE
    tick();
    s_ready = 1; s_rdata = 32'hAAAA5555;
    #1 chk("t6_ready", 32'({m1_ready, m0_ready}), 32'h0);
    chk("t6_m0_rdata", m0_rdata, 32'h0);
    chk("t6_m1_rdata", m1_rdata, 32'h0);
    tick();
    s_ready = 0;
    #1 chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_grant", 32'(grant), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
